// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the byte-addressable data memory.
// Holds the sweep FSM states, access-size encodings and the alignment rule.
package data_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  // Illegal when wider than the word or the offset is not a multiple of the size.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] ofs,
                                      input int nb);
    int nbytes;
    nbytes = 1 << size;
    return (nbytes > nb) || ((int'(ofs) & (nbytes - 1)) != 0);
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port word array with byte-lane write strobes and a registered read.
// One access per cycle, read data valid the cycle after re_i; storage is not reset.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter  int NUMWORDS  = 4096,
  parameter  int DATAWIDTH = 32,
  localparam int NB        = DATAWIDTH / 8,
  localparam int IW        = $clog2(NUMWORDS)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [IW-1:0]        idx_i,
  input  logic [NB-1:0]        be_i,
  input  logic [DATAWIDTH-1:0] wdata_i,
  output logic [DATAWIDTH-1:0] rdata_o
);

  logic [DATAWIDTH-1:0] mem_q [NUMWORDS];
  logic [DATAWIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem.sv
// Byte/half/word load-store memory with post-reset clear sweep (ready_o low while sweeping).
// Response RDLATENCY edges after acceptance (first edge included); no backpressure on responses.
module data_mem
  import data_mem_pkg::*;
#(
  parameter  int NUMWORDS  = 4096,
  parameter  int DATAWIDTH = 32,
  parameter  int RDLATENCY = 1,
  localparam int NB        = DATAWIDTH / 8,
  localparam int OFS       = $clog2(NB),
  localparam int IW        = $clog2(NUMWORDS),
  localparam int AW        = IW + OFS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 ready_o,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [1:0]           size_i,
  input  logic                 unsigned_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [DATAWIDTH-1:0] wdata_i,
  output logic                 rsp_valid_o,
  output logic                 rsp_err_o,
  output logic [DATAWIDTH-1:0] rdata_o
);

  state_e        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + IW'(1);
      if (&cnt_q) state_d = RUN;
    end
  end

  always_comb begin
    ready_o = (state_q == RUN);
  end

  logic                 accept;
  logic                 req_err;
  logic [OFS-1:0]       req_ofs;
  logic [IW-1:0]        req_idx;
  logic [NB-1:0]        st_be;
  logic [DATAWIDTH-1:0] st_dat;

  assign accept  = req_i && ready_o;
  assign req_ofs = addr_i[OFS-1:0];
  assign req_idx = addr_i[AW-1:OFS];
  assign req_err = misaligned(size_i, 3'(req_ofs), NB);

  // Lane o+k takes byte k of the right-aligned store data.
  always_comb begin
    st_be = '0;
    for (int b = 0; b < NB; b++) begin
      st_be[b] = (b >= int'(req_ofs)) && (b < int'(req_ofs) + (1 << size_i));
    end
    st_dat = wdata_i << {req_ofs, 3'b000};
  end

  logic                 arr_we, arr_re;
  logic [IW-1:0]        arr_idx;
  logic [NB-1:0]        arr_be;
  logic [DATAWIDTH-1:0] arr_wdat, arr_rdat;

  always_comb begin
    arr_we   = 1'b0;
    arr_re   = 1'b0;
    arr_idx  = req_idx;
    arr_be   = st_be;
    arr_wdat = st_dat;
    if (state_q == CLEAR) begin
      arr_we   = 1'b1;
      arr_idx  = cnt_q;
      arr_be   = '1;
      arr_wdat = '0;
    end else if (accept && !req_err) begin
      arr_we = we_i;
      arr_re = !we_i;
    end
  end

  data_mem_array #(
    .NUMWORDS (NUMWORDS),
    .DATAWIDTH(DATAWIDTH)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (arr_we),
    .re_i   (arr_re),
    .idx_i  (arr_idx),
    .be_i   (arr_be),
    .wdata_i(arr_wdat),
    .rdata_o(arr_rdat)
  );

  // First response stage sits alongside the array's registered read.
  logic           s1_vld_q, s1_vld_d;
  logic           s1_err_q, s1_err_d;
  logic           s1_load_q, s1_load_d;
  logic           s1_uns_q, s1_uns_d;
  logic [1:0]     s1_size_q, s1_size_d;
  logic [OFS-1:0] s1_ofs_q, s1_ofs_d;

  always_comb begin
    s1_vld_d  = accept;
    s1_err_d  = req_err;
    s1_load_d = !we_i;
    s1_uns_d  = unsigned_i;
    s1_size_d = size_i;
    s1_ofs_d  = req_ofs;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) s1_vld_q <= 1'b0;
    else       s1_vld_q <= s1_vld_d;
  end

  always_ff @(posedge clk_i) begin
    s1_err_q  <= s1_err_d;
    s1_load_q <= s1_load_d;
    s1_uns_q  <= s1_uns_d;
    s1_size_q <= s1_size_d;
    s1_ofs_q  <= s1_ofs_d;
  end

  logic [DATAWIDTH-1:0] shifted, fmt_dat;
  logic                 fill_bit;
  int                   fmt_bits;

  always_comb begin
    shifted  = arr_rdat >> {s1_ofs_q, 3'b000};
    fmt_bits = 8 << s1_size_q;
    if (fmt_bits > DATAWIDTH) fmt_bits = DATAWIDTH;
    fill_bit = shifted[fmt_bits-1] & ~s1_uns_q;
    fmt_dat  = '0;
    if (s1_load_q && !s1_err_q) begin
      for (int i = 0; i < DATAWIDTH; i++) begin
        fmt_dat[i] = (i < fmt_bits) ? shifted[i] : fill_bit;
      end
    end
  end

  logic                 out_vld, out_err;
  logic [DATAWIDTH-1:0] out_dat;

  if (RDLATENCY == 1) begin : g_direct
    assign out_vld = s1_vld_q;
    assign out_err = s1_err_q;
    assign out_dat = fmt_dat;
  end else begin : g_pipe
    localparam int PS = RDLATENCY - 1;
    logic                 pv_q [PS];
    logic                 pv_d [PS];
    logic                 pe_q [PS];
    logic                 pe_d [PS];
    logic [DATAWIDTH-1:0] pd_q [PS];
    logic [DATAWIDTH-1:0] pd_d [PS];

    always_comb begin
      pv_d[0] = s1_vld_q;
      pe_d[0] = s1_err_q;
      pd_d[0] = fmt_dat;
      for (int i = 1; i < PS; i++) begin
        pv_d[i] = pv_q[i-1];
        pe_d[i] = pe_q[i-1];
        pd_d[i] = pd_q[i-1];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < PS; i++) pv_q[i] <= 1'b0;
      end else begin
        pv_q <= pv_d;
      end
    end

    always_ff @(posedge clk_i) begin
      pe_q <= pe_d;
      pd_q <= pd_d;
    end

    assign out_vld = pv_q[PS-1];
    assign out_err = pe_q[PS-1];
    assign out_dat = pd_q[PS-1];
  end

  assign rsp_valid_o = out_vld;
  assign rsp_err_o   = out_vld & out_err;
  assign rdata_o     = out_vld ? out_dat : '0;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: vector table plus reset/latency sequences,
// responses checked against a scoreboard queue with expected arrival cycle.
module tb_data_mem;

  localparam int NW = 16;
  localparam int DW = 32;
  localparam int L  = 3;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    size = 2'd0;
  logic          uns = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          ready_o, rsp_valid_o, rsp_err_o;
  logic [DW-1:0] rdata_o;

  always #5 clk = ~clk;

  data_mem #(.NUMWORDS(NW), .DATAWIDTH(DW), .RDLATENCY(L)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .ready_o    (ready_o),
    .req_i      (req),
    .we_i       (we),
    .size_i     (size),
    .unsigned_i (uns),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .rsp_valid_o(rsp_valid_o),
    .rsp_err_o  (rsp_err_o),
    .rdata_o    (rdata_o)
  );

  typedef struct {
    logic          we;
    logic [1:0]    size;
    logic          uns;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          err;
    logic [DW-1:0] dat;
  } vec_t;

  typedef struct {
    logic          err;
    logic [DW-1:0] dat;
    int            cyc;
    int            tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   tag = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rsp_valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid_o=1 at cycle %0d with nothing outstanding", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("rsp_err[%0d]", e.tag), rsp_err_o, e.err);
        chk($sformatf("rsp_dat[%0d]", e.tag), rdata_o, e.dat);
        chk($sformatf("rsp_cyc[%0d]", e.tag), cyc, e.cyc + L - 1);
      end
    end
  end

  task automatic issue(input vec_t v);
    @(negedge clk);
    req = 1'b1; we = v.we; size = v.size; uns = v.uns; addr = v.addr; wdata = v.wdata;
    chk($sformatf("ready[%0d]", tag), ready_o, 1'b1);
    sb.push_back('{v.err, v.dat, cyc + 1, tag});
    tag++;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    req = 1'b0;
  endtask

  // Counts edges from the first edge with reset low until ready_o is seen high.
  task automatic wait_ready(input int stray_at);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (n == stray_at) begin
        chk("stray_ready", ready_o, 1'b0);
        req = 1'b1; we = 1'b1; size = 2'd2; addr = '0; wdata = 32'hDEADBEEF;
      end else begin
        req = 1'b0;
      end
    end while (!ready_o && n < 4 * NW);
    req = 1'b0;
    chk("clear_cycles", n, NW);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    sb.delete();
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_valid", rsp_valid_o, 1'b0);
      chk("rst_ready", ready_o, 1'b0);
    end
  endtask

  vec_t tbl[19];
  vec_t lat[4];

  initial begin
    tbl[0]  = '{1'b0, 2'd2, 1'b0, 6'h00, 32'h0,        1'b0, 32'h00000000};
    tbl[1]  = '{1'b1, 2'd2, 1'b0, 6'h10, 32'h11223344, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 6'h11, 32'h000000AB, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 2'd2, 1'b0, 6'h10, 32'h0,        1'b0, 32'h1122AB44};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 6'h11, 32'h0,        1'b0, 32'hFFFFFFAB};
    tbl[5]  = '{1'b0, 2'd0, 1'b1, 6'h11, 32'h0,        1'b0, 32'h000000AB};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 6'h12, 32'h0,        1'b0, 32'h00001122};
    tbl[7]  = '{1'b1, 2'd1, 1'b0, 6'h13, 32'h0000BEEF, 1'b1, 32'h0};
    tbl[8]  = '{1'b0, 2'd2, 1'b0, 6'h10, 32'h0,        1'b0, 32'h1122AB44};
    tbl[9]  = '{1'b0, 2'd3, 1'b0, 6'h10, 32'h0,        1'b1, 32'h0};
    tbl[10] = '{1'b0, 2'd1, 1'b0, 6'h10, 32'h0,        1'b0, 32'hFFFFAB44};
    tbl[11] = '{1'b1, 2'd1, 1'b0, 6'h16, 32'hCAFE7788, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 6'h14, 32'h0,        1'b0, 32'h77880000};
    tbl[13] = '{1'b0, 2'd0, 1'b1, 6'h17, 32'h0,        1'b0, 32'h00000077};
    tbl[14] = '{1'b0, 2'd2, 1'b0, 6'h12, 32'h0,        1'b1, 32'h0};
    tbl[15] = '{1'b1, 2'd0, 1'b0, 6'h3F, 32'hFFFFFF80, 1'b0, 32'h0};
    tbl[16] = '{1'b0, 2'd0, 1'b0, 6'h3F, 32'h0,        1'b0, 32'hFFFFFF80};
    tbl[17] = '{1'b0, 2'd1, 1'b1, 6'h3E, 32'h0,        1'b0, 32'h00008000};
    tbl[18] = '{1'b0, 2'd2, 1'b0, 6'h3C, 32'h0,        1'b0, 32'h80000000};

    lat[0] = '{1'b0, 2'd2, 1'b0, 6'h10, 32'h0, 1'b0, 32'h1122AB44};
    lat[1] = '{1'b0, 2'd2, 1'b0, 6'h14, 32'h0, 1'b0, 32'h77880000};
    lat[2] = '{1'b0, 2'd2, 1'b0, 6'h3C, 32'h0, 1'b0, 32'h80000000};
    lat[3] = '{1'b0, 2'd2, 1'b0, 6'h00, 32'h0, 1'b0, 32'h00000000};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", ready_o, 1'b0);
    chk("reset_valid", rsp_valid_o, 1'b0);
    chk("reset_err", rsp_err_o, 1'b0);
    chk("reset_rdata", rdata_o, 32'h0);

    // Release reset; a store driven while clearing must be dropped silently.
    @(negedge clk);
    rst = 1'b0;
    wait_ready(3);

    for (int i = 0; i < 19; i++) issue(tbl[i]);
    idle();
    repeat (L + 2) @(posedge clk);

    for (int i = 0; i < 4; i++) issue(lat[i]);
    idle();
    repeat (L + 2) @(posedge clk);

    // Reset mid-clear restarts the sweep from word 0.
    do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    do_reset();
    @(negedge clk);
    rst = 1'b0;
    wait_ready(0);

    // Reset with two loads in flight: both responses are discarded.
    issue(lat[0]);
    issue(lat[1]);
    do_reset();
    @(negedge clk);
    rst = 1'b0;
    wait_ready(0);
    issue('{1'b0, 2'd2, 1'b0, 6'h10, 32'h0, 1'b0, 32'h00000000});
    idle();

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem.md
# data_mem

Byte-addressable data memory for the CPU load/store path, replacing the word-only memory. It supports byte, half and full-word accesses with sign or zero extension and byte-lane write strobes. Read latency is parametrised and every request gets a response, with misaligned accesses flagged. After reset, the contents are cleared by a sweep state machine, one word per cycle, so the array can infer as block RAM.

## Interface
- NUMWORDS, 4096: number of DATAWIDTH-bit words; power of two, ≥ 2.
- DATAWIDTH, 32: word width; 32 or 64.
- RDLATENCY, 1: cycles from request acceptance to response; 1..4.
- Derived: NB = DATAWIDTH/8; OFS = $clog2(NB); AW = $clog2(NUMWORDS)+OFS.
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset; one clock, reset is synchronous and active-high.
- ready_o  out  1  high when requests are accepted (state RUN).
- req_i  in  1  request; accepted on an edge where req_i && ready_o.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  access is 2^size_i bytes (0 byte, 1 half, 2 word32, 3 word64).
- unsigned_i  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- addr_i  in  AW  byte address.
- wdata_i  in  DATAWIDTH  store data, right-aligned (low 2^size_i bytes used).
- rsp_valid_o  out  1  one-cycle pulse per accepted request.
- rsp_err_o  out  1  qualified by rsp_valid_o; access was illegal.
- rdata_o  out  DATAWIDTH  load result, qualified by rsp_valid_o; 0 for stores and errors.

## Operation
- States: CLEAR, RUN. rst_i forces CLEAR with sweep counter 0, regardless of current state or counter.
- CLEAR: writes 0 to word[cnt], increments cnt, and keeps ready_o=0. Moves to RUN on the edge that writes word NUMWORDS-1.
- RUN: ready_o=1. Requests are ignored whenever ready_o=0.
- Illegal request: (2^size_i > NB) or addr_i[OFS-1:0] not a multiple of 2^size_i.
  - The array is not modified.
  - The response has rsp_err_o=1 and rdata_o=0.
- Store: word index addr_i[AW-1:OFS], byte lane offset o = addr_i[OFS-1:0].
  - Strobes cover lanes o..o+2^size_i-1.
  - Lane o+k takes byte k of wdata_i.
  - Other lanes are untouched.
- Load: reads the indexed word at the acceptance edge and extracts lanes o..o+2^size_i-1, shifted to bit 0.
  - Extension to DATAWIDTH follows unsigned_i. Full-width loads ignore unsigned_i.
- Single port: one access per cycle; no read/write collision is possible.
- Response pipeline: RDLATENCY stages of {valid, err, data}. Reset clears all valid bits.
- Responses for accepted requests are never dropped or reordered.

## Timing
- Reset values:
  - ready_o=0, rsp_valid_o=0, rsp_err_o=0, rdata_o=0.
  - State CLEAR, counter 0.
- Clear duration: ready_o rises exactly NUMWORDS cycles after the first edge with rst_i low.
- Request accepted at edge N → rsp_valid_o high during cycle N+RDLATENCY (after edge N+RDLATENCY-1 … i.e. visible RDLATENCY edges later), for exactly one cycle.
- Back-to-back requests are accepted every cycle; the response stream is one per cycle.
- A load accepted the edge after a store to the same word returns the updated data.
- Reset asserted while responses are in flight: those responses are discarded and the sweep restarts at word 0.
- Reset asserted mid-CLEAR: the counter returns to 0 and ready_o stays 0.

## Structure
- Package data_mem_pkg holds:
  - State enum {CLEAR, RUN}.
  - Size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, SZ_DWORD=3.
  - Function for the misalignment check.
- Sub-module data_mem_array holds the storage:
  - Synchronous, single port, NB byte-write strobes, registered read.
  - No reset on storage.
- The top level holds the FSM, sweep counter, lane alignment and extension logic, and the response pipeline.

## Test plan
- Reset released with NUMWORDS=16 → ready_o low for exactly 16 cycles. A store issued while ready_o is low is ignored and produces no response; a later word load at 0x0 returns 0x00000000.
- Store word 0x11223344 @0x10, then store byte 0xAB @0x11, then load word @0x10 → rdata_o=0x1122AB44, rsp_err_o=0.
- After that, load byte @0x11 with unsigned_i=0 → 0xFFFFFFAB. The same load with unsigned_i=1 → 0x000000AB. Load half @0x12 with unsigned_i=0 → 0x00001122.
- Store half 0xBEEF @0x13 → rsp_err_o=1 and rdata_o=0. A following load word @0x10 still returns 0x1122AB44. Size 3 with DATAWIDTH=32 also gives rsp_err_o=1.
- RDLATENCY=3, with loads on 4 consecutive cycles → 4 consecutive rsp_valid_o pulses starting 3 edges after the first acceptance, data in issue order.
- Reset pulsed mid-clear and again with 2 responses in flight → no rsp_valid_o appears after reset, and ready_o returns NUMWORDS cycles later.
